// File: rtl/vector_stream_downsizer.sv
// Lane-width converter: splits NUMBERS_IN-lane beats into NUMBERS_OUT-lane sub-beats, regenerating last/keep.
// Optional index path enabled by defining VECTOR_DOWNSIZER_INDEX_EN; otherwise m_index is tied to zero.
module vector_stream_downsizer #(
    parameter int unsigned NUMBERS_IN    = 8,
    parameter int unsigned NUMBERS_OUT   = 2,
    parameter int unsigned NUMBER_WIDTH  = 32,
    parameter int unsigned VECTOR_LENGTH = 32,
    localparam int unsigned IW  = $clog2(VECTOR_LENGTH),
    localparam int unsigned KIW = (NUMBERS_IN > 1) ? $clog2(NUMBERS_IN) : 1,
    localparam int unsigned KOW = (NUMBERS_OUT > 1) ? $clog2(NUMBERS_OUT) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [NUMBER_WIDTH*NUMBERS_IN-1:0]   s_data,
    input  logic [IW*NUMBERS_IN-1:0]             s_index,
    input  logic                                 s_last,
    input  logic [KIW-1:0]                       s_keep,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [NUMBER_WIDTH*NUMBERS_OUT-1:0]  m_data,
    output logic [IW*NUMBERS_OUT-1:0]            m_index,
    output logic                                 m_last,
    output logic [KOW-1:0]                       m_keep
);

    localparam int unsigned RATIO = NUMBERS_IN / NUMBERS_OUT;
    localparam int unsigned SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned OW    = NUMBER_WIDTH * NUMBERS_OUT;
    localparam int unsigned OIW   = IW * NUMBERS_OUT;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                           state;
    state_t                           state_nxt;
    logic [SW-1:0]                    sub;
    logic [SW-1:0]                    sub_nxt;
    logic [SW-1:0]                    n_sub;
    logic [NUMBER_WIDTH*NUMBERS_IN-1:0] held_data;
    logic                             held_last;
    logic [KIW-1:0]                   held_keep;
    logic                             full;
    logic                             at_end;
    logic                             load;

    assign full    = (state == ST_FULL);
    assign at_end  = (sub == n_sub);
    assign s_ready = !rst && (!full || (m_ready && at_end));
    assign load    = s_valid && s_ready;

    // Next state: a load always restarts at sub-beat 0, which also covers the back-to-back reload.
    always_comb begin
        state_nxt = state;
        sub_nxt   = sub;
        if (load) begin
            state_nxt = ST_FULL;
            sub_nxt   = '0;
        end else if (full && m_ready) begin
            if (sub < n_sub) begin
                sub_nxt = SW'(sub + 1'b1);
            end else begin
                state_nxt = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            sub       <= '0;
            n_sub     <= '0;
            held_data <= '0;
            held_last <= 1'b0;
            held_keep <= '0;
        end else begin
            state <= state_nxt;
            sub   <= sub_nxt;
            if (load) begin
                held_data <= s_data;
                held_last <= s_last;
                held_keep <= s_keep;
                n_sub     <= s_last ? SW'(s_keep / NUMBERS_OUT) : SW'(RATIO - 1);
            end
        end
    end

    // Sub-beat lane select from the holding register.
    always_comb begin
        m_data = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (sub == SW'(i)) begin
                m_data = held_data[i*OW +: OW];
            end
        end
    end

`ifdef VECTOR_DOWNSIZER_INDEX_EN
    logic [IW*NUMBERS_IN-1:0] held_index;

    always_ff @(posedge clk) begin
        if (rst) begin
            held_index <= '0;
        end else if (load) begin
            held_index <= s_index;
        end
    end

    always_comb begin
        m_index = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (sub == SW'(i)) begin
                m_index = held_index[i*OIW +: OIW];
            end
        end
    end
`else
    logic unused_index;

    assign unused_index = ^s_index;
    assign m_index      = '0;
`endif

    // Keep is forced to zero while empty so the idle bus matches its reset value.
    assign m_valid = full;
    assign m_last  = full && held_last && at_end;
    assign m_keep  = m_last ? KOW'(held_keep % NUMBERS_OUT)
                   : (full ? KOW'(NUMBERS_OUT - 1) : '0);

endmodule
